// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the 16-bit MIPS pipeline.
//   DATA_W / ADDR_W / NUM_REGS : register file geometry
//   FWD_*                      : operand forwarding-select encodings
package mips_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_DM  = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/regfile_32x16.sv
// regfile_32x16: general-purpose register array, 2 async read ports, 1 sync write port.
//   clk, rst_n     : clock, asynchronous active-low clear of every register
//   wr_addr/wr_data: written every rising edge unless wr_addr == 0
//   rd_addr_a/b    : read addresses; rd_data_a/b return contents before the edge
// R0 always reads zero and is never written.
module regfile_32x16
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // No write enable: upstream parks wr_addr at 0 when nothing should be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_addr != '0) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];

endmodule

// File: rtl/register_bank.sv
// register_bank: decode-stage register file plus operand forwarding/immediate select.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ans_ex/ans_dm/ans_wb: forwarded results; ans_dm is also the write-back data
//   imm, imm_sel        : immediate and its override of operand B
//   RA, RB              : source register indices
//   RW_dm               : write-back destination (0 = no write)
//   mux_sel_A/B         : operand source selects (FWD_REG/EX/DM/WB)
//   A, B                : registered operands to the execute stage
module register_bank
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW_dm,
  input  logic [1:0]        mux_sel_A,
  input  logic [1:0]        mux_sel_B,
  input  logic              imm_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  logic [DATA_W-1:0] reg_a, reg_b;
  logic [DATA_W-1:0] a_d, b_d;

  regfile_32x16 #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_addr   (RW_dm),
    .wr_data   (ans_dm),
    .rd_addr_a (RA),
    .rd_addr_b (RB),
    .rd_data_a (reg_a),
    .rd_data_b (reg_b)
  );

  always_comb begin
    a_d = reg_a;
    unique case (mux_sel_A)
      FWD_REG: a_d = reg_a;
      FWD_EX:  a_d = ans_ex;
      FWD_DM:  a_d = ans_dm;
      FWD_WB:  a_d = ans_wb;
      default: a_d = reg_a;
    endcase
  end

  always_comb begin
    b_d = reg_b;
    if (imm_sel) begin
      b_d = imm;
    end else begin
      unique case (mux_sel_B)
        FWD_REG: b_d = reg_b;
        FWD_EX:  b_d = ans_ex;
        FWD_DM:  b_d = ans_dm;
        FWD_WB:  b_d = ans_wb;
        default: b_d = reg_b;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
      B <= '0;
    end else begin
      A <= a_d;
      B <= b_d;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] ans_ex = '0, ans_dm = '0, ans_wb = '0, imm = '0;
  logic [4:0]  RA = '0, RB = '0, RW_dm = '0;
  logic [1:0]  mux_sel_A = FWD_REG, mux_sel_B = FWD_REG;
  logic        imm_sel = 1'b0;
  logic [15:0] A, B;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    bit          chk_b;
  } exp_t;

  exp_t sb[$];

  register_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ans_ex    (ans_ex),
    .ans_dm    (ans_dm),
    .ans_wb    (ans_wb),
    .imm       (imm),
    .RA        (RA),
    .RB        (RB),
    .RW_dm     (RW_dm),
    .mux_sel_A (mux_sel_A),
    .mux_sel_B (mux_sel_B),
    .imm_sel   (imm_sel),
    .A         (A),
    .B         (B)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: A/B are presented every edge; pop one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ".A"}, A, e.a);
      if (e.chk_b) check({e.name, ".B"}, B, e.b);
    end
  end

  // Issue one cycle of (already driven) stimulus with its expected result.
  task automatic step(input string name, input logic [15:0] ea, input logic [15:0] eb,
                      input bit chk_b);
    exp_t e;
    e.name = name; e.a = ea; e.b = eb; e.chk_b = chk_b;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Power-on reset with a real falling edge.
    #2 rst_n = 1'b0;
    #1;
    check("por_A", A, 16'h0000);
    check("por_B", B, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    RA = 5'd7; RB = 5'd7;
    step("post_reset", 16'h0000, 16'h0000, 1'b1);

    // Immediate overrides mux_sel_B; forwarding on A.
    ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000;
    imm = 16'hFFFF; imm_sel = 1'b1; mux_sel_B = FWD_EX; mux_sel_A = FWD_EX;
    step("imm_fwd_ex", 16'hC000, 16'hFFFF, 1'b1);
    imm_sel = 1'b0; mux_sel_A = FWD_DM;
    step("noimm_fwd_dm", 16'hD000, 16'hC000, 1'b1);
    mux_sel_A = FWD_WB; mux_sel_B = FWD_WB;
    step("fwd_wb", 16'hE000, 16'hE000, 1'b1);
    mux_sel_A = FWD_REG; RA = 5'd0; mux_sel_B = FWD_DM;
    step("r0_fwd_dm", 16'h0000, 16'hD000, 1'b1);

    // Write edge: same-edge read returns old contents.
    RW_dm = 5'd7; ans_dm = 16'hD000; RA = 5'd7; RB = 5'd7;
    mux_sel_A = FWD_REG; mux_sel_B = FWD_REG;
    step("write_edge_old", 16'h0000, 16'h0000, 1'b1);
    RW_dm = 5'd0;
    step("read_back7", 16'hD000, 16'hD000, 1'b1);

    // Writes to R0 are discarded.
    ans_dm = 16'h1234; RA = 5'd0; RB = 5'd7; mux_sel_B = FWD_DM;
    step("r0_write_edge", 16'h0000, 16'h1234, 1'b1);
    mux_sel_B = FWD_REG;
    step("r0_reads_zero", 16'h0000, 16'hD000, 1'b1);

    // Independent ports.
    RW_dm = 5'd5; ans_dm = 16'h0AAA; RA = 5'd7;
    step("wr5", 16'hD000, 16'hD000, 1'b1);
    RW_dm = 5'd6; ans_dm = 16'h0BBB; RA = 5'd5;
    step("wr6", 16'h0AAA, 16'hD000, 1'b1);
    RW_dm = 5'd31; ans_dm = 16'hBEEF; RA = 5'd5; RB = 5'd6;
    step("ports_5_6", 16'h0AAA, 16'h0BBB, 1'b1);
    RW_dm = 5'd7; ans_dm = 16'h1111; RA = 5'd31; RB = 5'd5;
    step("read31", 16'hBEEF, 16'h0AAA, 1'b1);
    RW_dm = 5'd0; RA = 5'd7; RB = 5'd31;
    step("overwrite7", 16'h1111, 16'hBEEF, 1'b1);

    // Mid-cycle asynchronous reset; writes blocked while held.
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_A", A, 16'h0000);
    check("mid_rst_B", B, 16'h0000);
    RW_dm = 5'd5; ans_dm = 16'hFFFF; mux_sel_A = FWD_EX; ans_ex = 16'hC000;
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_A", A, 16'h0000);
    check("held_rst_B", B, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    RW_dm = 5'd0; mux_sel_A = FWD_REG; RA = 5'd5; RB = 5'd31;
    step("cleared_5_31", 16'h0000, 16'h0000, 1'b1);
    RA = 5'd7;
    step("cleared_7", 16'h0000, 16'h0000, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
